// File: rtl/split_mix_sequencer_if.sv
// split_mix_sequencer_if: host-side control and actuator bundle of the split-mix sequencer.
// master = host issuing start, slave = the sequencer driving valves and mixers.
interface split_mix_sequencer_if #(
  parameter int N_LEAF  = 8,
  parameter int LEVEL_W = 3
);
  // start has no ready: a one-cycle request that is honoured only in IDLE (busy and
  // done both low) and silently dropped otherwise; done and err are one-cycle strobes.
  logic                start;
  logic [N_LEAF-1:0]   fill_mask;
  logic                busy;
  logic                done;
  logic                err;
  logic [N_LEAF-1:0]   fill_valve;
  logic [N_LEAF-2:0]   mix_en;
  logic                out_valve;
  logic [LEVEL_W-1:0]  level;

  modport master (
    output start, fill_mask,
    input  busy, done, err, fill_valve, mix_en, out_valve, level
  );

  modport slave (
    input  start, fill_mask,
    output busy, done, err, fill_valve, mix_en, out_valve, level
  );
endinterface

// File: rtl/split_mix_sequencer.sv
// split_mix_sequencer: timed fill, leaf-to-root mix and drain controller for a binary mixer tree.
// Define SPLIT_MIX_FLUSH_EN to add a FLUSH phase (all inlets and outlet open) after DRAIN.
module split_mix_sequencer #(
  parameter int N_LEAF      = 8,
  parameter int FILL_CYCLES = 16,
  parameter int MIX_CYCLES  = 32,
  parameter int CNT_W       = 8,
  localparam int LEVELS     = $clog2(N_LEAF),
  localparam int LEVEL_W    = $clog2(LEVELS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  split_mix_sequencer_if.slave  bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_MIX   = 3'd2,
    S_DRAIN = 3'd3,
`ifdef SPLIT_MIX_FLUSH_EN
    S_FLUSH = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MIX_LAST  = CNT_W'(MIX_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(LEVELS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [N_LEAF-1:0]   mask_q, mask_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [N_LEAF-1:0]   fill_valve_q, fill_valve_d;
  logic [N_LEAF-2:0]   mix_en_q, mix_en_d;
  logic                out_valve_q, out_valve_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    level_d = level_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.start) begin
          if (|bus.fill_mask) begin
            mask_d  = bus.fill_mask;
            state_d = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (timer_q == FILL_LAST) begin
          timer_d = '0;
          level_d = TOP_LEVEL;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        if (timer_q == MIX_LAST) begin
          timer_d = '0;
          if (level_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            level_d = level_q - LEVEL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (timer_q == FILL_LAST) begin
          timer_d = '0;
`ifdef SPLIT_MIX_FLUSH_EN
          state_d = S_FLUSH;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SPLIT_MIX_FLUSH_EN
      S_FLUSH: begin
        if (timer_q == FILL_LAST) begin
          timer_d = '0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        level_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the phase.
  always_comb begin
    int lv;
    lv           = int'(level_d);
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fill_valve_d = '0;
    mix_en_d     = '0;
    out_valve_d  = 1'b0;
    case (state_d)
      S_FILL: begin
        busy_d       = 1'b1;
        fill_valve_d = mask_d;
      end
      S_MIX: begin
        busy_d = 1'b1;
        // Node i sits on level lv when (i+1)>>lv == 1; leaf j falls under position j>>(LEVELS-lv).
        for (int i = 0; i < N_LEAF - 1; i++) begin
          if (((i + 1) >> lv) == 1) begin
            for (int j = 0; j < N_LEAF; j++) begin
              if ((j >> (LEVELS - lv)) == (i + 1 - (1 << lv))) begin
                mix_en_d[i] = mix_en_d[i] | mask_d[j];
              end
            end
          end
        end
      end
      S_DRAIN: begin
        busy_d      = 1'b1;
        out_valve_d = 1'b1;
      end
`ifdef SPLIT_MIX_FLUSH_EN
      S_FLUSH: begin
        busy_d       = 1'b1;
        fill_valve_d = '1;
        out_valve_d  = 1'b1;
      end
`endif
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      level_q      <= '0;
      mask_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fill_valve_q <= '0;
      mix_en_q     <= '0;
      out_valve_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      level_q      <= level_d;
      mask_q       <= mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fill_valve_q <= fill_valve_d;
      mix_en_q     <= mix_en_d;
      out_valve_q  <= out_valve_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.fill_valve = fill_valve_q;
  assign bus.mix_en     = mix_en_q;
  assign bus.out_valve  = out_valve_q;
  assign bus.level      = level_q;
  assign dbg_state_o    = state_q;

endmodule
